// File: rtl/fpa_accumulator.sv
// Streaming floating-point accumulator wrapped around the combinational fpa adder.
// Build option: define FPA_ACCUMULATOR_ZERO_SKIP_EN to count zero operands without an ADD cycle.

module fpa (
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic [31:0] out
);
    logic        swap;
    logic [30:0] big_mag;
    logic [30:0] small_mag;
    logic        big_sign;
    logic        small_sign;
    logic [7:0]  big_exp;
    logic [7:0]  small_exp;
    logic [7:0]  exp_diff;
    logic [23:0] big_man;
    logic [23:0] small_man;
    logic [23:0] sum;
    logic [4:0]  lz;

    function automatic logic [4:0] lzc23(input logic [22:0] v);
        logic [4:0] n;
        n = 5'd23;
        for (int i = 0; i < 23; i++) begin
            if (v[i]) n = 5'(22 - i);
        end
        return n;
    endfunction

    // Normalised magnitudes compare correctly as plain unsigned {exp, mant} words.
    always_comb begin
        swap       = in2[30:0] > in1[30:0];
        big_mag    = swap ? in2[30:0] : in1[30:0];
        small_mag  = swap ? in1[30:0] : in2[30:0];
        big_sign   = swap ? in2[31] : in1[31];
        small_sign = swap ? in1[31] : in2[31];
        big_exp    = big_mag[30:23];
        small_exp  = small_mag[30:23];
        exp_diff   = big_exp - small_exp;
        big_man    = {1'b0, big_mag[22:0]};
        small_man  = (exp_diff > 8'd23) ? 24'd0 : ({1'b0, small_mag[22:0]} >> exp_diff);
        sum        = (big_sign == small_sign) ? big_man + small_man : big_man - small_man;
        lz         = lzc23(sum[22:0]);

        out = '0;
        if (in1[30:0] == '0) begin
            out = in2;
        end else if (in2[30:0] == '0) begin
            out = in1;
        end else if (sum == '0) begin
            out = '0;
        end else if (sum[23]) begin
            if (big_exp == 8'hFF) out = {big_sign, 8'hFF, 23'h7FFFFF};
            else                  out = {big_sign, big_exp + 8'd1, sum[23:1]};
        end else if ({3'b000, lz} <= big_exp) begin
            out = {big_sign, big_exp - {3'b000, lz}, sum[22:0] << lz};
        end
    end
endmodule

module fpa_accumulator #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [31:0]      m_data,
    output logic [CNT_W-1:0] m_count,
    output logic             m_valid,
    input  logic             m_ready
);
    typedef enum logic [1:0] {StAcc, StAdd, StDone} state_e;

    state_e           state_q;
    state_e           state_d;
    logic [31:0]      acc_q;
    logic [31:0]      acc_d;
    logic [31:0]      op_q;
    logic [31:0]      op_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             last_pend_q;
    logic             last_pend_d;
    logic [31:0]      add_out;

    fpa u_fpa (
        .in1(acc_q),
        .in2(op_q),
        .out(add_out)
    );

    always_comb begin
        cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StAcc;
            acc_q       <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
            last_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            last_pend_q <= last_pend_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        last_pend_d = last_pend_q;
        unique case (state_q)
            StAcc: begin
                if (s_valid) begin
                    if (cnt_q == '0) begin
                        // First element seeds the sum directly; no add needed.
                        acc_d = s_data;
                        cnt_d = CNT_W'(1);
                        if (s_last) state_d = StDone;
`ifdef FPA_ACCUMULATOR_ZERO_SKIP_EN
                    end else if (s_data[30:0] == '0) begin
                        cnt_d = cnt_inc;
                        if (s_last) state_d = StDone;
`endif
                    end else begin
                        op_d        = s_data;
                        last_pend_d = s_last;
                        state_d     = StAdd;
                    end
                end
            end
            StAdd: begin
                acc_d   = add_out;
                cnt_d   = cnt_inc;
                state_d = last_pend_q ? StDone : StAcc;
            end
            StDone: begin
                if (m_ready) begin
                    acc_d       = '0;
                    cnt_d       = '0;
                    last_pend_d = 1'b0;
                    state_d     = StAcc;
                end
            end
            default: state_d = StAcc;
        endcase
    end

    // Outputs are forced low while reset is asserted.
    always_comb begin
        s_ready = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_count = '0;
        if (!rst) begin
            s_ready = (state_q == StAcc);
            m_valid = (state_q == StDone);
            m_data  = acc_q;
            m_count = cnt_q;
        end
    end
endmodule

// File: tb/tb_fpa_accumulator.sv
// Self-checking bench for fpa_accumulator: directed vectors, timing corners, random sums.
module tb_fpa_accumulator;
    localparam int CntW = 16;
`ifdef FPA_ACCUMULATOR_ZERO_SKIP_EN
    localparam bit ZeroSkip = 1'b1;
`else
    localparam bit ZeroSkip = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     s_data;
    logic            s_valid;
    logic            s_last;
    logic            s_ready;
    logic [31:0]     m_data;
    logic [CntW-1:0] m_count;
    logic            m_valid;
    logic            m_ready;
    logic            s_ready2;
    logic [31:0]     m_data2;
    logic [1:0]      m_count2;
    logic            m_valid2;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    fpa_accumulator #(.CNT_W(CntW)) dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .m_data(m_data), .m_count(m_count), .m_valid(m_valid),
        .m_ready(m_ready)
    );

    // Narrow counter instance shares the stimulus to exercise saturation.
    fpa_accumulator #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready2), .m_data(m_data2), .m_count(m_count2), .m_valid(m_valid2),
        .m_ready(m_ready)
    );

    typedef struct {
        logic [2:0][31:0] d;
        int               n;
        logic [31:0]      sum;
    } vec_t;

    function automatic vec_t mkvec(input logic [31:0] a, input logic [31:0] b,
                                   input logic [31:0] c, input int n, input logic [31:0] sum);
        vec_t v;
        v.d[0] = a;
        v.d[1] = b;
        v.d[2] = c;
        v.n    = n;
        v.sum  = sum;
        return v;
    endfunction

    // Encode an integer in the chip format: value = mant/2^22 * 2^exp.
    function automatic logic [31:0] enc(input int v);
        int a;
        int p;
        if (v == 0) return 32'h0;
        a = (v < 0) ? -v : v;
        p = $clog2(a + 1) - 1;
        return {(v < 0), 8'(p), 23'(a << (22 - p))};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        s_data  = d;
        s_last  = last;
        s_valid = 1'b1;
        while (!s_ready && n < 20) begin
            step();
            n++;
        end
        if (!s_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: s_ready got 0 want 1");
        end
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic recv(input logic [31:0] want, input int n_want, input bit zero_sum);
        int n;
        n = 0;
        while (!m_valid && n < 20) begin
            step();
            n++;
        end
        check("m_valid", 32'(m_valid), 32'd1);
        check("m_valid_sat", 32'(m_valid2), 32'd1);
        if (zero_sum) begin
            check("m_data_zero", {1'b0, m_data[30:0]}, 32'h0);
            check("m_data_zero_sat", {1'b0, m_data2[30:0]}, 32'h0);
        end else begin
            check("m_data", m_data, want);
            check("m_data_sat", m_data2, want);
        end
        check("m_count", 32'(m_count), 32'(n_want));
        check("m_count_sat", 32'(m_count2), (n_want > 3) ? 32'd3 : 32'(n_want));
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        int   n;
        int   s;
        int   v;

        vecs[0] = mkvec(32'h01CE0000, 32'h0, 32'h0, 1, 32'h01CE0000);
        vecs[1] = mkvec(32'h01CE0000, 32'h024A4000, 32'h0, 2, 32'h02714000);
        vecs[2] = mkvec(32'h01CE0000, 32'h824A4000, 32'h0, 2, 32'h81C68000);
        vecs[3] = mkvec(32'h01540000, 32'h00000000, 32'h00600000, 3, 32'h016C0000);
        vecs[4] = mkvec(32'h00600000, 32'h80600000, 32'h0, 2, 32'h00000000);
        vecs[5] = mkvec(32'h00000000, 32'h01CE0000, 32'h0, 2, 32'h01CE0000);
        vecs[6] = mkvec(32'h01CE0000, 32'h00000000, 32'h0, 2, 32'h01CE0000);

        rst = 1'b1; s_data = '0; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
        step();
        step();
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_s_ready", 32'(s_ready), 32'd1);
        check("post_rst_m_valid", 32'(m_valid), 32'd0);
        check("post_rst_m_data", m_data, 32'h0);
        check("post_rst_m_count", 32'(m_count), 32'd0);

        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < vecs[i].n; k++) send(vecs[i].d[k], k == vecs[i].n - 1);
            recv(vecs[i].sum, vecs[i].n, 1'b0);
        end

        // Single element: result valid straight after the handshake edge.
        s_data = 32'h01CE0000; s_last = 1'b1; s_valid = 1'b1;
        step();
        s_valid = 1'b0; s_last = 1'b0;
        check("single_m_valid", 32'(m_valid), 32'd1);
        check("single_s_ready", 32'(s_ready), 32'd0);
        check("single_m_data", m_data, 32'h01CE0000);
        check("single_m_count", 32'(m_count), 32'd1);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;

        // Two elements, then five cycles of backpressure.
        send(32'h01CE0000, 1'b0);
        check("two_s_ready_after_first", 32'(s_ready), 32'd1);
        s_data = 32'h024A4000; s_last = 1'b1; s_valid = 1'b1;
        step();
        s_valid = 1'b0; s_last = 1'b0;
        check("two_add_s_ready", 32'(s_ready), 32'd0);
        check("two_add_m_valid", 32'(m_valid), 32'd0);
        step();
        check("two_m_valid", 32'(m_valid), 32'd1);
        check("two_m_data", m_data, 32'h02714000);
        check("two_m_count", 32'(m_count), 32'd2);
        for (int c = 0; c < 5; c++) begin
            step();
            check("hold_m_valid", 32'(m_valid), 32'd1);
            check("hold_m_data", m_data, 32'h02714000);
            check("hold_s_ready", 32'(s_ready), 32'd0);
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("release_m_valid", 32'(m_valid), 32'd0);
        check("release_s_ready", 32'(s_ready), 32'd1);
        check("release_m_count", 32'(m_count), 32'd0);

        // Reset in the ADD cycle of the second element.
        send(32'h01CE0000, 1'b0);
        s_data = 32'h024A4000; s_last = 1'b0; s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_s_ready", 32'(s_ready), 32'd0);
        check("mid_rst_m_data", m_data, 32'h0);
        step();
        rst = 1'b0;
        #1;
        check("after_rst_s_ready", 32'(s_ready), 32'd1);
        check("after_rst_m_valid", 32'(m_valid), 32'd0);
        check("after_rst_m_data", m_data, 32'h0);
        send(32'h00600000, 1'b1);
        recv(32'h00600000, 1, 1'b0);

        // Reset while a result is waiting.
        send(32'h01CE0000, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("done_rst_m_valid", 32'(m_valid), 32'd0);
        check("done_rst_s_ready", 32'(s_ready), 32'd1);

        // Zero operand timing depends on the build option.
        send(32'h01540000, 1'b0);
        s_data = 32'h00000000; s_last = 1'b0; s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        check("zero_s_ready", 32'(s_ready), 32'(ZeroSkip));
        send(32'h00600000, 1'b1);
        recv(32'h016C0000, 3, 1'b0);

        // Random integer sums, exact in the format, against plain integer arithmetic.
        for (int t = 0; t < 40; t++) begin
            n = int'($urandom_range(1, 6));
            s = 0;
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 5) == 0) v = 0;
                else v = int'($urandom_range(0, 8190)) - 4095;
                repeat ($urandom_range(0, 2)) step();
                s += v;
                send(enc(v), k == n - 1);
            end
            repeat ($urandom_range(0, 3)) step();
            recv(enc(s), n, s == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
